// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel/line counters, visible-area flag, delayed H/V sync
// and line/frame start pulses, all registered and advancing on the pixel clock enable.
module vga_sync_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC_LEN = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC_LEN = 2,
  parameter int V_BP       = 33,
  parameter bit SYNC_POL   = 1'b0,
  parameter int SYNC_DELAY = 0
) (
  input  logic        F_CLOCK,
  input  logic        RESET,
  input  logic        PIX_CE,
  output logic        F_ON,
  output logic [9:0]  F_ROW,
  output logic [10:0] F_COLUMN,
  output logic        H_SYNC,
  output logic        V_SYNC,
  output logic        LINE_START,
  output logic        FRAME_START
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC_LEN + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC_LEN + V_BP;

  if (H_TOTAL > 2048) begin : g_bad_h_total
    $error("vga_sync_gen: H_TOTAL exceeds 2048");
  end
  if (V_TOTAL > 1024) begin : g_bad_v_total
    $error("vga_sync_gen: V_TOTAL exceeds 1024");
  end
  if (SYNC_DELAY < 0 || SYNC_DELAY > 4) begin : g_bad_delay
    $error("vga_sync_gen: SYNC_DELAY must be 0..4");
  end

  localparam logic [10:0] COL_LAST  = 11'(H_TOTAL - 1);
  localparam logic [9:0]  ROW_LAST  = 10'(V_TOTAL - 1);
  localparam logic [11:0] H_VIS_END = 12'(H_VISIBLE);
  localparam logic [10:0] V_VIS_END = 11'(V_VISIBLE);
  // Sync windows use one extra bit so an end bound equal to the total cannot wrap.
  localparam logic [11:0] H_SYNC_BEG = 12'(H_VISIBLE + H_FP);
  localparam logic [11:0] H_SYNC_END = 12'(H_VISIBLE + H_FP + H_SYNC_LEN);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_VISIBLE + V_FP + V_SYNC_LEN);

  logic        col_wrap;
  logic [10:0] col_next;
  logic [9:0]  row_next;
  logic        on_next;
  logic        h_raw;
  logic        v_raw;
  logic [SYNC_DELAY:0] h_pipe;
  logic [SYNC_DELAY:0] v_pipe;

  // Everything below is derived from the counters as they will be after this
  // pixel step, so registered outputs line up with F_ROW/F_COLUMN.
  always_comb begin
    // NOTE: always_comb uses blocking assignments and gives every output a
    // default first, so no path through the block can infer a latch.
    col_wrap = (F_COLUMN == COL_LAST);
    col_next = col_wrap ? 11'd0 : F_COLUMN + 11'd1;
    row_next = F_ROW;
    if (col_wrap) begin
      row_next = (F_ROW == ROW_LAST) ? 10'd0 : F_ROW + 10'd1;
    end
    on_next = ({1'b0, col_next} < H_VIS_END) && ({1'b0, row_next} < V_VIS_END);
    h_raw = ({1'b0, col_next} >= H_SYNC_BEG) && ({1'b0, col_next} < H_SYNC_END)
            ? SYNC_POL : ~SYNC_POL;
    v_raw = ({1'b0, row_next} >= V_SYNC_BEG) && ({1'b0, row_next} < V_SYNC_END)
            ? SYNC_POL : ~SYNC_POL;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge F_CLOCK) begin
    if (RESET) begin
      F_COLUMN    <= COL_LAST;
      F_ROW       <= ROW_LAST;
      F_ON        <= 1'b0;
      LINE_START  <= 1'b0;
      FRAME_START <= 1'b0;
      // NOTE: the delay line is a handful of flops, not a RAM, so it is reset
      // to inactive levels; a stale active level would otherwise leak out.
      h_pipe      <= {(SYNC_DELAY + 1){~SYNC_POL}};
      v_pipe      <= {(SYNC_DELAY + 1){~SYNC_POL}};
    end else begin
      LINE_START  <= 1'b0;
      FRAME_START <= 1'b0;
      if (PIX_CE) begin
        F_COLUMN    <= col_next;
        F_ROW       <= row_next;
        F_ON        <= on_next;
        LINE_START  <= col_wrap;
        FRAME_START <= col_wrap && (row_next == 10'd0);
        h_pipe[0]   <= h_raw;
        v_pipe[0]   <= v_raw;
        for (int i = 1; i <= SYNC_DELAY; i++) begin
          h_pipe[i] <= h_pipe[i-1];
          v_pipe[i] <= v_pipe[i-1];
        end
      end
    end
  end

  assign H_SYNC = h_pipe[SYNC_DELAY];
  assign V_SYNC = v_pipe[SYNC_DELAY];

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a behavioural raster model feeds a scoreboard for three
// builds (default, SYNC_DELAY=2, and a small active-high timing) plus spot checks.
module tb_vga_sync_gen;

  typedef struct {
    int hv, hf, hs, hb, vv, vf, vs, vb;
    bit pol;
    int dly;
  } cfg_t;

  typedef struct {
    int col, row;
    bit on, hsync, vsync, ls, fs;
    bit [4:0] hh, vh;
  } st_t;

  typedef struct {
    st_t d0, d2, ds;
  } exp_t;

  cfg_t c0 = '{hv:640, hf:16, hs:96, hb:48, vv:480, vf:10, vs:2, vb:33, pol:1'b0, dly:0};
  cfg_t c2 = '{hv:640, hf:16, hs:96, hb:48, vv:480, vf:10, vs:2, vb:33, pol:1'b0, dly:2};
  cfg_t cs = '{hv:8, hf:2, hs:3, hb:2, vv:6, vf:1, vs:2, vb:2, pol:1'b1, dly:1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b0;
  always #5 clk = ~clk;

  logic on0, hs0, vs0, ls0, fs0;
  logic [9:0] row0;
  logic [10:0] col0;
  logic on2, hs2, vs2, ls2, fs2;
  logic [9:0] row2;
  logic [10:0] col2;
  logic on_s, hs_s, vs_s, ls_s, fs_s;
  logic [9:0] row_s;
  logic [10:0] col_s;

  vga_sync_gen dut0 (
    .F_CLOCK(clk), .RESET(rst), .PIX_CE(ce), .F_ON(on0), .F_ROW(row0), .F_COLUMN(col0),
    .H_SYNC(hs0), .V_SYNC(vs0), .LINE_START(ls0), .FRAME_START(fs0)
  );

  vga_sync_gen #(.SYNC_DELAY(2)) dut2 (
    .F_CLOCK(clk), .RESET(rst), .PIX_CE(ce), .F_ON(on2), .F_ROW(row2), .F_COLUMN(col2),
    .H_SYNC(hs2), .V_SYNC(vs2), .LINE_START(ls2), .FRAME_START(fs2)
  );

  vga_sync_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC_LEN(3), .H_BP(2),
    .V_VISIBLE(6), .V_FP(1), .V_SYNC_LEN(2), .V_BP(2),
    .SYNC_POL(1'b1), .SYNC_DELAY(1)
  ) dut_s (
    .F_CLOCK(clk), .RESET(rst), .PIX_CE(ce), .F_ON(on_s), .F_ROW(row_s), .F_COLUMN(col_s),
    .H_SYNC(hs_s), .V_SYNC(vs_s), .LINE_START(ls_s), .FRAME_START(fs_s)
  );

  int total = 0;
  int bad = 0;
  int clk_idx = 0;
  st_t m0, m2, ms;
  exp_t sb[$];

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference raster: position, visible flag, sync history and start pulses.
  function automatic st_t model(input cfg_t c, input st_t s, input bit r, input bit e);
    st_t n;
    int ht, vt;
    bit rh, rv;
    ht = c.hv + c.hf + c.hs + c.hb;
    vt = c.vv + c.vf + c.vs + c.vb;
    n = s;
    n.ls = 1'b0;
    n.fs = 1'b0;
    if (r) begin
      n.col = ht - 1;
      n.row = vt - 1;
      n.on = 1'b0;
      n.hh = {5{~c.pol}};
      n.vh = {5{~c.pol}};
    end else if (e) begin
      n.col = (s.col + 1) % ht;
      if (n.col == 0) n.row = (s.row + 1) % vt;
      n.on = (n.col < c.hv) && (n.row < c.vv);
      n.ls = (n.col == 0);
      n.fs = (n.col == 0) && (n.row == 0);
      rh = (n.col >= c.hv + c.hf && n.col < c.hv + c.hf + c.hs) ? c.pol : ~c.pol;
      rv = (n.row >= c.vv + c.vf && n.row < c.vv + c.vf + c.vs) ? c.pol : ~c.pol;
      n.hh = {s.hh[3:0], rh};
      n.vh = {s.vh[3:0], rv};
    end
    n.hsync = n.hh[c.dly];
    n.vsync = n.vh[c.dly];
    return n;
  endfunction

  task automatic cmp(input string n, input st_t e, input bit on, input int row, input int col,
                     input bit hs, input bit vs, input bit ls, input bit fs);
    check({n, ".col"}, col, e.col);
    check({n, ".row"}, row, e.row);
    check({n, ".on"}, int'(on), int'(e.on));
    check({n, ".hsync"}, int'(hs), int'(e.hsync));
    check({n, ".vsync"}, int'(vs), int'(e.vsync));
    check({n, ".line_start"}, int'(ls), int'(e.ls));
    check({n, ".frame_start"}, int'(fs), int'(e.fs));
  endtask

  // One clock: drive on the falling edge, push expectations, compare 1 ns after the rising edge.
  task automatic step(input bit r, input bit e);
    exp_t x;
    @(negedge clk);
    rst = r;
    ce = e;
    m0 = model(c0, m0, r, e);
    m2 = model(c2, m2, r, e);
    ms = model(cs, ms, r, e);
    x.d0 = m0;
    x.d2 = m2;
    x.ds = ms;
    sb.push_back(x);
    @(posedge clk);
    #1;
    clk_idx++;
    x = sb.pop_front();
    cmp("d0", x.d0, on0, int'(row0), int'(col0), hs0, vs0, ls0, fs0);
    cmp("d2", x.d2, on2, int'(row2), int'(col2), hs2, vs2, ls2, fs2);
    cmp("ds", x.ds, on_s, int'(row_s), int'(col_s), hs_s, vs_s, ls_s, fs_s);
  endtask

  initial begin
    int ls_cnt, fs_cnt, fall0, rise0, fall2, rise2, low_cnt, last_fs, pix_cnt, k;
    bit have_fs;
    m0 = '{default: 0};
    m2 = '{default: 0};
    ms = '{default: 0};

    // Reset state
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("rst_col", int'(col0), 799);
    check("rst_row", int'(row0), 524);
    check("rst_on", int'(on0), 0);
    check("rst_hsync", int'(hs0), 1);
    check("rst_vsync", int'(vs0), 1);
    check("rst_pulses", int'({ls0, fs0}), 0);
    check("rst_small_col", int'(col_s), 14);
    check("rst_small_row", int'(row_s), 10);
    check("rst_small_sync", int'({hs_s, vs_s}), 0);

    // First full line with PIX_CE held high
    ls_cnt = 0; fs_cnt = 0; fall0 = -1; rise0 = -1; fall2 = -1; rise2 = -1;
    for (int i = 0; i <= 800; i++) begin
      step(1'b0, 1'b1);
      if (i == 0) begin
        check("first_pos", int'(col0) + 1000 * int'(row0), 0);
        check("first_frame_start", int'(fs0), 1);
        check("first_line_start", int'(ls0), 1);
        check("on_0_0", int'(on0), 1);
      end
      if (i == 639) check("on_0_639", int'(on0), 1);
      if (i == 640) check("on_0_640", int'(on0), 0);
      ls_cnt += int'(ls0);
      fs_cnt += int'(fs0);
      if (fall0 < 0 && hs0 == 1'b0) fall0 = i;
      if (fall0 >= 0 && rise0 < 0 && hs0 == 1'b1) rise0 = i;
      if (fall2 < 0 && hs2 == 1'b0) fall2 = i;
      if (fall2 >= 0 && rise2 < 0 && hs2 == 1'b1) rise2 = i;
    end
    check("line_start_count", ls_cnt, 2);
    check("frame_start_count", fs_cnt, 1);
    check("after_line_col", int'(col0), 0);
    check("after_line_row", int'(row0), 1);
    check("hsync_fall_d0", fall0, 656);
    check("hsync_rise_d0", rise0, 752);
    check("hsync_fall_d2", fall2, 658);
    check("hsync_rise_d2", rise2, 754);

    // One line at half-rate PIX_CE; the small build cycles through several frames meanwhile
    low_cnt = 0; have_fs = 1'b0; last_fs = 0; pix_cnt = 0;
    for (int i = 0; i < 800; i++) begin
      for (int ph = 0; ph < 2; ph++) begin
        step(1'b0, ph == 0);
        if (hs0 == 1'b0) low_cnt++;
        if (ph == 0) begin
          if (fs_s) begin
            if (have_fs) begin
              check("small_frame_period", clk_idx - last_fs, 330);
              check("small_on_pixels", pix_cnt, 48);
            end
            have_fs = 1'b1;
            last_fs = clk_idx;
            pix_cnt = 0;
          end
          pix_cnt += int'(on_s);
          if (row_s == 10'd5 && col_s == 11'd7) check("small_on_last_visible", int'(on_s), 1);
          if (row_s == 10'd6 && col_s == 11'd0) check("small_on_row6", int'(on_s), 0);
          if (row_s == 10'd0 && col_s == 11'd8) check("small_on_col8", int'(on_s), 0);
        end
      end
    end
    check("hsync_low_clocks", low_cnt, 192);
    check("small_frames_seen", int'(have_fs), 1);

    // Random PIX_CE with occasional resets, scoreboard only
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0);
    end

    // Reset mid-frame on the small build at (4,5)
    k = 0;
    while (!(row_s == 10'd4 && col_s == 11'd5) && k < 400) begin
      step(1'b0, 1'b1);
      k++;
    end
    check("reach_row4_col5", int'(k < 400), 1);
    step(1'b1, 1'b0);
    check("midrst_col", int'(col_s), 14);
    check("midrst_row", int'(row_s), 10);
    check("midrst_on", int'(on_s), 0);
    check("midrst_d0_col", int'(col0), 799);
    step(1'b0, 1'b0);
    check("midrst_hold_fs", int'(fs_s), 0);
    step(1'b0, 1'b1);
    check("midrst_pos", int'(col_s) + 100 * int'(row_s), 0);
    check("midrst_fs", int'(fs_s), 1);

    // RESET and PIX_CE together
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    check("rst_ce_fs", int'(fs0), 0);
    check("rst_ce_ls", int'(ls0), 0);
    check("rst_ce_col", int'(col0), 799);
    check("rst_ce_row", int'(row0), 524);
    step(1'b0, 1'b1);
    check("rst_ce_then_fs", int'(fs0), 1);
    step(1'b0, 1'b0);
    check("pulse_clears", int'({ls0, fs0}), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
